// File: rtl/wlan_conv_pkg.sv
// rtl/wlan_conv_pkg.sv - shared constants and branch-label helper for the K=7 convolutional code
//
// Shared by the transmit encoder and the receive Viterbi decoder.
// Contents: constraint length, generator polynomials, rate codes, branch_label().
package wlan_conv_pkg;

    localparam int         K  = 7;
    localparam logic [6:0] G0 = 7'o133;
    localparam logic [6:0] G1 = 7'o171;

    typedef enum logic [1:0] {
        RATE_1_2 = 2'd0,
        RATE_2_3 = 2'd1,
        RATE_3_4 = 2'd2
    } rate_t;

    // Encoder output pair {A,B} when in_bit enters a register holding 'state'
    // (last six inputs, newest in the MSB).
    function automatic logic [1:0] branch_label(input logic [5:0] state, input logic in_bit);
        logic [6:0] v;
        v = {in_bit, state};
        return {^(v & G0), ^(v & G1)};
    endfunction

endpackage

// File: rtl/conv_depuncture.sv
// rtl/conv_depuncture.sv - depuncturer turning the serial coded stream into (A,B) pairs with erasures
//
// Ports:
//   Clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   en       : data_in valid this cycle
//   rate     : 0=1/2, 1=2/3, 2=3/4, 3 treated as 1/2; sampled at pattern start
//   data_in  : one coded bit per en cycle
//   step     : pair complete this cycle (combinational, qualifies the outputs below)
//   pair_a   : received A bit
//   pair_b   : received B bit
//   erase_a  : A position is an erasure
//   erase_b  : B position is an erasure
module conv_depuncture
    import wlan_conv_pkg::*;
(
    input  logic       Clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] rate,
    input  logic       data_in,
    output logic       step,
    output logic       pair_a,
    output logic       pair_b,
    output logic       erase_a,
    output logic       erase_b
);

    logic [1:0] phase;
    logic [1:0] phase_next;
    logic [1:0] last_phase;
    rate_t      rate_q;
    rate_t      cur_rate;
    logic       a_hold;

    // Phase layout shared by all rates: 0 holds A0, 1 completes (A0,B0),
    // 2 completes (A1,E), 3 completes (E,B2). Rate only picks the wrap point.
    always_comb begin
        cur_rate   = rate_q;
        last_phase = 2'd1;
        phase_next = phase + 2'd1;
        step       = 1'b0;
        pair_a     = 1'b0;
        pair_b     = 1'b0;
        erase_a    = 1'b0;
        erase_b    = 1'b0;

        if (phase == 2'd0) begin
            cur_rate = (rate == 2'd3) ? RATE_1_2 : rate_t'(rate);
        end

        case (cur_rate)
            RATE_2_3: last_phase = 2'd2;
            RATE_3_4: last_phase = 2'd3;
            default:  last_phase = 2'd1;
        endcase

        if (phase == last_phase) begin
            phase_next = 2'd0;
        end

        if (en) begin
            case (phase)
                2'd1: begin
                    step   = 1'b1;
                    pair_a = a_hold;
                    pair_b = data_in;
                end
                2'd2: begin
                    step    = 1'b1;
                    pair_a  = data_in;
                    erase_b = 1'b1;
                end
                2'd3: begin
                    step    = 1'b1;
                    pair_b  = data_in;
                    erase_a = 1'b1;
                end
                default: begin
                    step = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            phase  <= 2'd0;
            rate_q <= RATE_1_2;
            a_hold <= 1'b0;
        end else if (en) begin
            phase <= phase_next;
            if (phase == 2'd0) begin
                rate_q <= cur_rate;
                a_hold <= data_in;
            end
        end
    end

endmodule

// File: rtl/viterbi_decoder.sv
// rtl/viterbi_decoder.sv - 64-state hard-decision Viterbi decoder, register-exchange survivors
//
// Optional feature macro: VITERBI_BEST_STATE_EN (output from minimum-metric state,
// one extra cycle of latency). Default build outputs from state 0.
//
// Ports:
//   Clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   en        : data_in valid; when low all state holds
//   rate      : 0=1/2, 1=2/3, 2=3/4, 3 treated as 1/2
//   data_in   : coded bit, transmit order
//   data_out  : decoded info bit
//   valid_out : one-cycle strobe qualifying data_out
module viterbi_decoder
    import wlan_conv_pkg::*;
#(
    parameter int DEPTH = 48,
    parameter int PMW   = 8
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] rate,
    input  logic       data_in,
    output logic       data_out,
    output logic       valid_out
);

    localparam int NS = 64;
    localparam int CW = $clog2(DEPTH + 1);

    logic step;
    logic pair_a;
    logic pair_b;
    logic erase_a;
    logic erase_b;

    conv_depuncture u_depuncture (
        .Clk     (Clk),
        .reset   (reset),
        .en      (en),
        .rate    (rate),
        .data_in (data_in),
        .step    (step),
        .pair_a  (pair_a),
        .pair_b  (pair_b),
        .erase_a (erase_a),
        .erase_b (erase_b)
    );

    logic [PMW-1:0]   pm        [NS];
    logic [PMW-1:0]   pm_next   [NS];
    logic [DEPTH-1:0] surv      [NS];
    logic [DEPTH-1:0] surv_next [NS];
    logic [CW-1:0]    step_cnt;
    logic             full;

    assign full = (step_cnt == CW'(DEPTH));

    // State s = {u, p[5:1]}: its predecessors are p = {s[4:0], x}, and u = s[5]
    // is the info bit carried by both incoming branches.
    for (genvar s = 0; s < NS; s++) begin : g_acs
        localparam int P0 = (s % 32) * 2;
        localparam int P1 = P0 + 1;
        localparam int IN = s / 32;

        logic [1:0]       lab0;
        logic [1:0]       lab1;
        logic [1:0]       bm0;
        logic [1:0]       bm1;
        logic [PMW-1:0]   cand0;
        logic [PMW-1:0]   cand1;
        logic [PMW-1:0]   diff;
        logic             pick1;
        logic [DEPTH-1:0] surv_sel;

        assign lab0  = branch_label(6'(P0), 1'(IN));
        assign lab1  = branch_label(6'(P1), 1'(IN));
        assign bm0   = {1'b0, ~erase_a & (pair_a ^ lab0[1])} + {1'b0, ~erase_b & (pair_b ^ lab0[0])};
        assign bm1   = {1'b0, ~erase_a & (pair_a ^ lab1[1])} + {1'b0, ~erase_b & (pair_b ^ lab1[0])};
        assign cand0 = pm[P0] + PMW'(bm0);
        assign cand1 = pm[P1] + PMW'(bm1);
        // Modular compare: predecessor 1 wins only when strictly smaller.
        assign diff  = cand0 - cand1;
        assign pick1 = !diff[PMW-1] && (diff != '0);

        assign surv_sel     = pick1 ? surv[P1] : surv[P0];
        assign pm_next[s]   = pick1 ? cand1 : cand0;
        assign surv_next[s] = {surv_sel[DEPTH-2:0], 1'(IN)};
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NS; i++) begin
                pm[i]   <= (i == 0) ? '0 : PMW'(2 ** (PMW - 2));
                surv[i] <= '0;
            end
            step_cnt <= '0;
        end else if (step) begin
            for (int i = 0; i < NS; i++) begin
                pm[i]   <= pm_next[i];
                surv[i] <= surv_next[i];
            end
            if (!full) begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

`ifdef VITERBI_BEST_STATE_EN
    // Heap-ordered comparator tree: leaves NS-1..2*NS-2 hold states 0..63,
    // left subtrees carry lower indices so keeping left on ties gives lowest index.
    logic [PMW-1:0] tree_pm  [2*NS-1];
    logic [5:0]     tree_idx [2*NS-1];
    logic [NS-1:0]  oldest;
    logic [5:0]     best_idx;
    logic [NS-1:0]  best_bits;
    logic           best_vld;

    for (genvar s = 0; s < NS; s++) begin : g_oldest
        assign oldest[s] = surv[s][DEPTH-1];
    end

    always_comb begin
        logic [PMW-1:0] d;
        d = '0;
        for (int i = 0; i < 2 * NS - 1; i++) begin
            tree_pm[i]  = '0;
            tree_idx[i] = '0;
        end
        for (int i = 0; i < NS; i++) begin
            tree_pm[NS-1+i]  = pm[i];
            tree_idx[NS-1+i] = 6'(i);
        end
        for (int i = NS - 2; i >= 0; i--) begin
            d = tree_pm[2*i+2] - tree_pm[2*i+1];
            if (d[PMW-1]) begin
                tree_pm[i]  = tree_pm[2*i+2];
                tree_idx[i] = tree_idx[2*i+2];
            end else begin
                tree_pm[i]  = tree_pm[2*i+1];
                tree_idx[i] = tree_idx[2*i+1];
            end
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            best_idx  <= '0;
            best_bits <= '0;
            best_vld  <= 1'b0;
            data_out  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            best_vld  <= step && full;
            valid_out <= best_vld;
            if (step && full) begin
                best_idx  <= tree_idx[0];
                best_bits <= oldest;
            end
            if (best_vld) begin
                data_out <= best_bits[best_idx];
            end
        end
    end
`else
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            data_out  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= step && full;
            if (step && full) begin
                data_out <= surv[0][DEPTH-1];
            end
        end
    end
`endif

endmodule
